// File: rtl/counter_sec.sv
// Seconds stage of the digital clock: prescales clk to a 1 Hz base, counts
// seconds 0-59 with preset, and emits the minute carry, a 1 Hz tick and a colon blink.
module counter_sec #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int CARRY_CYCLES = 4
) (
  input  logic       clk,
  input  logic       _CR,
  input  logic       PE,
  input  logic [7:0] pre_sec,
  input  logic       EN,
  output logic [7:0] show_sec,
  output logic       cin_sec,
  output logic       tick_1hz,
  output logic       blink,
  output logic       load_err
);

  localparam int PW  = $clog2(CLK_HZ);
  localparam int PLW = $clog2(CARRY_CYCLES + 1);

  localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0]  PRE_HALF = PW'(CLK_HZ / 2);
  localparam logic [PLW-1:0] PLS_INIT = PLW'(CARRY_CYCLES - 1);
  localparam logic [7:0]     SEC_MAX  = 8'd59;

  logic [PW-1:0]  pre_cnt;
  logic [PW-1:0]  pre_cnt_nxt;
  logic [PLW-1:0] pls_cnt;
  logic           sec_adv;

  // Next prescaler value and the "advance seconds" strobe; preset beats run.
  always_comb begin
    pre_cnt_nxt = pre_cnt;
    sec_adv     = 1'b0;
    if (PE) begin
      pre_cnt_nxt = '0;
    end else if (EN) begin
      if (pre_cnt == PRE_LAST) begin
        pre_cnt_nxt = '0;
        sec_adv     = 1'b1;
      end else begin
        pre_cnt_nxt = pre_cnt + 1'b1;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge _CR) begin
    if (!_CR) begin
      pre_cnt  <= '0;
      pls_cnt  <= '0;
      show_sec <= 8'd0;
      cin_sec  <= 1'b0;
      tick_1hz <= 1'b0;
      blink    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      pre_cnt  <= pre_cnt_nxt;
      tick_1hz <= sec_adv;
      // Blink is derived from the next count so it stays aligned with pre_cnt.
      blink    <= (pre_cnt_nxt >= PRE_HALF);

      if (PE) begin
        cin_sec <= 1'b0;
        pls_cnt <= '0;
        if (pre_sec <= SEC_MAX) begin
          show_sec <= pre_sec;
          load_err <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else begin
        if (sec_adv) begin
          show_sec <= (show_sec == SEC_MAX) ? 8'd0 : show_sec + 8'd1;
        end

        if (sec_adv && show_sec == SEC_MAX) begin
          cin_sec <= 1'b1;
          pls_cnt <= PLS_INIT;
        end else if (cin_sec) begin
          if (pls_cnt == '0) begin
            cin_sec <= 1'b0;
          end else begin
            pls_cnt <= pls_cnt - 1'b1;
          end
        end
      end
    end
  end

endmodule
